// File: rtl/cache_structs_def.sv
// Shared cache/memory bus definitions.
// Provides the block payload type, the request/response structs exchanged
// between the cache and the memory model, the memory responder FSM state
// type and its default latency.
package cache_structs_def;

    localparam int unsigned DATA_WIDTH          = 32;
    localparam int unsigned ADDR_WIDTH          = 16;
    localparam int unsigned BLOCK_SIZE          = 4;
    localparam int unsigned OFFSET_WIDTH        = $clog2(BLOCK_SIZE);
    localparam int unsigned MEM_DEFAULT_LATENCY = 4;

    // One cache block; word 0 sits in the least significant lane.
    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    typedef struct packed {
        logic                  cs;
        logic                  rw;   // 1 = write
        logic [ADDR_WIDTH-1:0] addr;
        block_t                data;
    } memory_request_t;

    typedef struct packed {
        logic   ack;
        block_t data;
    } memory_response_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } mem_resp_state_t;

endpackage

// File: rtl/mem_block_ram.sv
// Block-wide single-port storage for the memory responder.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears rdata only)
//   en, we   : port enable and write select
//   idx      : block index
//   wdata    : block written when en && we
//   rdata    : registered read block; holds the read result for exactly the
//              cycle after an enabled read and is zero otherwise
// Contents start at zero and are never touched by reset.
module mem_block_ram
    import cache_structs_def::*;
#(
    parameter int unsigned BLOCKS = 256,
    localparam int unsigned IDX_W = $clog2(BLOCKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  block_t           wdata,
    output block_t           rdata
);

    block_t mem [BLOCKS] = '{default: '0};

    // Write port
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    // Read register doubles as the response data register, so it self-clears
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[idx];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency block memory model answering cache block requests.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   mem_req            : cs, rw (1 = write), addr, block data from the cache
//   mem_res            : one-cycle ack plus read data (zero unless acking a read)
//   rd_count, wr_count : completed read/write counters, only when the
//                        MEM_RESP_STATS_EN macro is defined
// A request is captured in IDLE, waits LATENCY edges in BUSY (aborted if cs
// drops) and is acknowledged for one cycle in ACK.
module mem_responder
    import cache_structs_def::*;
#(
    parameter int unsigned LATENCY    = MEM_DEFAULT_LATENCY,
    parameter int unsigned MEM_BLOCKS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  memory_request_t  mem_req,
    output memory_response_t mem_res
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]      rd_count,
    output logic [31:0]      wr_count
`endif
);

    localparam int unsigned IDX_W = $clog2(MEM_BLOCKS);
    localparam int unsigned CNT_W = 8;

    mem_resp_state_t  state;
    logic [CNT_W-1:0] cnt;
    logic             rw_q;
    logic [IDX_W-1:0] idx_q;
    block_t           data_q;
    logic             ack_q;
    block_t           rd_block;
    logic             fire_c;

    // Last BUSY edge with the request still held: storage access happens here
    assign fire_c = !rst && (state == BUSY) && mem_req.cs && (cnt == '0);

    mem_block_ram #(
        .BLOCKS (MEM_BLOCKS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (fire_c),
        .we    (rw_q),
        .idx   (idx_q),
        .wdata (data_q),
        .rdata (rd_block)
    );

    assign mem_res.ack  = ack_q;
    assign mem_res.data = rd_block;

    // Request FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rw_q   <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
            ack_q  <= 1'b0;
`ifdef MEM_RESP_STATS_EN
            rd_count <= '0;
            wr_count <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req.cs) begin
                        rw_q   <= mem_req.rw;
                        // Offset bits shifted out, upper bits truncated
                        idx_q  <= IDX_W'(mem_req.addr >> OFFSET_WIDTH);
                        data_q <= mem_req.data;
                        cnt    <= CNT_W'(LATENCY - 1);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (!mem_req.cs) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= ACK;
                        ack_q <= 1'b1;
`ifdef MEM_RESP_STATS_EN
                        if (rw_q) begin
                            wr_count <= wr_count + 32'd1;
                        end else begin
                            rd_count <= rd_count + 32'd1;
                        end
`endif
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
